// File: rtl/ain_backprop.sv
// ain_backprop: backward-pass partner of the 2-input Q2.2 ReLU neuron.
// Accumulates d*x gradients over BATCH samples, then applies a shift-scaled,
// saturating update to the live weights and reports it on a valid/ready port.

// One weight lane: gradient accumulator plus the live weight it updates.
module ain_backprop_lane #(
    parameter int ACC_W    = 12,
    parameter int LR_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_w,
    input  logic [3:0] w_init,
    input  logic       accept,
    input  logic [4:0] d,
    input  logic [3:0] x,
    input  logic       apply,
    output logic [3:0] w
);
    logic signed [8:0]       d_ext;
    logic signed [8:0]       x_ext;
    logic signed [8:0]       prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W:0]   sum;
    logic        [3:0]       w_sat;

    // Q3.2 * Q2.2 -> Q5.4; the 9-bit product cannot overflow (worst case -16*-8).
    assign d_ext    = {{4{d[4]}}, d};
    assign x_ext    = {{5{x[3]}}, x};
    assign prod     = d_ext * x_ext;
    assign prod_ext = {{(ACC_W-9){prod[8]}}, prod};

    // Floor shift: 2 bits bring Q.4 back to Q.2, the rest is the learning rate.
    assign step = acc >>> (2 + LR_SHIFT);
    assign sum  = {{(ACC_W-3){w[3]}}, w} + {step[ACC_W-1], step};

    // Clamp the widened sum into the Q2.2 range [-8, +7].
    always_comb begin
        w_sat = sum[3:0];
        if (sum > $signed((ACC_W+1)'(7)))
            w_sat = 4'b0111;
        else if (sum < -$signed((ACC_W+1)'(8)))
            w_sat = 4'b1000;
    end

    // Weight/accumulator state: reset, then load, then apply, then accumulate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w   <= '0;
            acc <= '0;
        end else if (load_w) begin
            w   <= w_init;
            acc <= '0;
        end else if (apply) begin
            w   <= w_sat;
            acc <= '0;
        end else if (accept) begin
            acc <= acc + prod_ext;
        end
    end
endmodule

module ain_backprop #(
    parameter int BATCH    = 4,
    parameter int LR_SHIFT = 2,
    parameter int ACC_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_w,
    input  logic [3:0] w1_init,
    input  logic [3:0] w2_init,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_x1,
    input  logic [3:0] s_x2,
    input  logic [4:0] s_err,
    input  logic       s_act,
    output logic [3:0] w1,
    output logic [3:0] w2,
    output logic       m_valid,
    input  logic       m_ready
);
    localparam int NUM_LANES = 2;
    localparam int CNT_W     = (BATCH > 1) ? $clog2(BATCH) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

    state_t                          state, next_state;
    logic   [CNT_W-1:0]              cnt;
    logic                            accept;
    logic                            last;
    logic   [4:0]                    d;
    logic   [NUM_LANES-1:0][3:0]     x_v;
    logic   [NUM_LANES-1:0][3:0]     w_init_v;
    logic   [NUM_LANES-1:0][3:0]     w_v;

    assign s_ready  = rst && (state == IDLE) && !load_w;
    assign accept   = s_valid && s_ready;
    assign last     = (cnt == CNT_W'(BATCH - 1));
    // Inactive ReLU passes no gradient, but the sample still counts.
    assign d        = s_act ? s_err : 5'd0;
    assign x_v      = {s_x2, s_x1};
    assign w_init_v = {w2_init, w1_init};
    assign w1       = w_v[0];
    assign w2       = w_v[1];

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            ain_backprop_lane #(
                .ACC_W   (ACC_W),
                .LR_SHIFT(LR_SHIFT)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .load_w(load_w),
                .w_init(w_init_v[i]),
                .accept(accept),
                .d     (d),
                .x     (x_v[i]),
                .apply (state == APPLY),
                .w     (w_v[i])
            );
        end
    endgenerate

    // Next-state: batch completion -> APPLY -> HOLD until consumed; load wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && last) next_state = APPLY;
            APPLY:   next_state = HOLD;
            HOLD:    if (m_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (load_w)
            next_state = IDLE;
    end

    // State, batch counter and registered update-valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            m_valid <= 1'b0;
        end else begin
            state   <= next_state;
            m_valid <= (next_state == HOLD);
            if (load_w)
                cnt <= '0;
            else if (accept)
                cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ain_backprop.sv
// Self-checking bench for ain_backprop: directed cases plus random batches,
// scored against a floor-division / clamp reference model.
module tb_ain_backprop;
    localparam int BATCH    = 4;
    localparam int LR_SHIFT = 2;
    localparam int ACC_W    = 12;

    logic       clk = 1'b0;
    logic       rst, load_w;
    logic [3:0] w1_init, w2_init;
    logic       s_valid, s_ready;
    logic [3:0] s_x1, s_x2;
    logic [4:0] s_err;
    logic       s_act;
    logic [3:0] w1, w2;
    logic       m_valid, m_ready;

    always #5 clk = ~clk;

    ain_backprop #(.BATCH(BATCH), .LR_SHIFT(LR_SHIFT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .load_w(load_w), .w1_init(w1_init), .w2_init(w2_init),
        .s_valid(s_valid), .s_ready(s_ready), .s_x1(s_x1), .s_x2(s_x2),
        .s_err(s_err), .s_act(s_act), .w1(w1), .w2(w2),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    typedef struct { int w1; int w2; } upd_t;

    int   checks = 0, errors = 0;
    int   wm[2], accm[2], cntm;
    upd_t sb[$];
    bit   mr_rand = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat4(int v);
        return (v > 7) ? 7 : ((v < -8) ? -8 : v);
    endfunction

    function automatic int floor_div(int a, int b);
        int q = a / b;
        if ((a % b != 0) && (a < 0)) q--;
        return q;
    endfunction

    // Reference: sum gradients, after BATCH samples scale by 2^-(2+LR), clamp.
    task automatic model_sample(int x1, int x2, int e, int a);
        int dd = a ? e : 0;
        accm[0] += dd * x1;
        accm[1] += dd * x2;
        cntm++;
        if (cntm == BATCH) begin
            for (int i = 0; i < 2; i++) begin
                wm[i]   = sat4(wm[i] + floor_div(accm[i], 1 << (2 + LR_SHIFT)));
                accm[i] = 0;
            end
            cntm = 0;
            sb.push_back('{wm[0], wm[1]});
        end
    endtask

    task automatic model_clear(int a, int b);
        wm[0] = a; wm[1] = b;
        accm[0] = 0; accm[1] = 0;
        cntm = 0;
        sb.delete();
    endtask

    task automatic send(int x1, int x2, int e, int a);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_x1 = 4'(x1); s_x2 = 4'(x2); s_err = 5'(e); s_act = 1'(a);
        #1;
        while (!s_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1 within 100 cycles");
        end else begin
            model_sample(x1, x2, e, a);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mr_rand = 1'b0; m_ready = 1'b0; s_valid = 1'b0; rst = 1'b0;
        #1 chk("s_ready_in_rst", s_ready, 0);
        @(negedge clk); @(negedge clk); #1;
        chk("rst_w1", $signed(w1), 0);
        chk("rst_w2", $signed(w2), 0);
        chk("rst_m_valid", m_valid, 0);
        rst = 1'b1;
        model_clear(0, 0);
        @(negedge clk); #1 chk("post_rst_s_ready", s_ready, 1);
    endtask

    // Load with a sample offered in the same cycle; that sample must be refused.
    task automatic do_load(int a, int b);
        @(negedge clk);
        mr_rand = 1'b0; m_ready = 1'b0;
        load_w = 1'b1; w1_init = 4'(a); w2_init = 4'(b);
        s_valid = 1'b1; s_x1 = 4'd7; s_x2 = 4'd7; s_err = 5'd15; s_act = 1'b1;
        #1 chk("load_s_ready", s_ready, 0);
        @(posedge clk); #1;
        load_w = 1'b0; s_valid = 1'b0;
        model_clear(a, b);
        @(negedge clk); #1;
        chk("load_w1", $signed(w1), a);
        chk("load_w2", $signed(w2), b);
        chk("load_m_valid", m_valid, 0);
        chk("load_s_ready_after", s_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        mr_rand = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        @(negedge clk); @(negedge clk);
        chk("pending_updates", sb.size(), 0);
    endtask

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(negedge clk);
            if (mr_rand) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: score each consumed update, and watch m_valid never drops unasked.
    bit   pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b0;
    upd_t exp_u;
    initial begin
        forever begin
            @(negedge clk); #2;
            if (pv && !pr && !pl && prst && !m_valid) begin
                checks++; errors++;
                $display("FAIL m_valid_drop: got 0 expected 1 (no m_ready)");
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update: got w1=%0d w2=%0d expected none",
                             $signed(w1), $signed(w2));
                end else begin
                    exp_u = sb.pop_front();
                    chk("upd_w1", $signed(w1), exp_u.w1);
                    chk("upd_w2", $signed(w2), exp_u.w2);
                end
            end
            pv = m_valid; pr = m_ready; pl = load_w; prst = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; load_w = 1'b0; w1_init = '0; w2_init = '0;
        s_valid = 1'b0; s_x1 = '0; s_x2 = '0; s_err = '0; s_act = 1'b0; m_ready = 1'b0;
        model_clear(0, 0);
        do_reset();

        // w=1.0, one active sample x1=1.0,err=1.0 plus inactive fillers -> w1=1.25.
        do_load(4, 4);
        send(4, 0, 4, 1);
        chk("t1_w1_hold1", $signed(w1), 4);
        send(7, 7, 15, 0);
        chk("t1_w1_hold2", $signed(w1), 4);
        send(7, 7, 15, 0);
        chk("t1_w1_hold3", $signed(w1), 4);
        send(-8, 5, -16, 0);
        @(negedge clk); #1;
        chk("t1_apply_m_valid", m_valid, 0);
        chk("t1_apply_s_ready", s_ready, 0);
        @(negedge clk); #1;
        chk("t1_m_valid", m_valid, 1);
        chk("t1_w1", $signed(w1), 5);
        chk("t1_w2", $signed(w2), 4);
        // Back-pressure: update held for 5 cycles, then consumed.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_m_valid", m_valid, 1);
            chk("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_m_valid", m_valid, 0);
        chk("bp_release_s_ready", s_ready, 1);
        m_ready = 1'b0;
        drain();

        // Saturation at both ends.
        do_load(7, -8);
        repeat (BATCH) send(7, 7, 15, 1);
        drain();
        chk("sat_hi_w1", $signed(w1), 7);
        chk("sat_w2", $signed(w2), 7);
        do_load(-8, 7);
        repeat (BATCH) send(7, 7, -16, 1);
        drain();
        chk("sat_lo_w1", $signed(w1), -8);
        chk("sat_lo_w2", $signed(w2), -8);

        // Inactive samples: weights unchanged, update still reported.
        do_load(3, -2);
        repeat (BATCH) send(7, 7, 15, 0);
        drain();
        chk("inact_w1", $signed(w1), 3);
        chk("inact_w2", $signed(w2), -2);

        // Full batch of small gradients: acc=16 -> +0.25 only after 4th sample.
        do_load(4, 0);
        for (int i = 0; i < BATCH; i++) begin
            send(4, 0, 1, 1);
            if (i < BATCH - 1) chk("b4_hold_w1", $signed(w1), 4);
        end
        drain();
        chk("b4_w1", $signed(w1), 5);

        // Reset mid-batch discards partial sums.
        do_load(2, -3);
        send(7, 7, 15, 1);
        send(7, 7, 15, 1);
        do_reset();
        repeat (BATCH) send(4, -4, 4, 1);
        @(negedge clk); @(negedge clk); #1;
        chk("post_rst_m_valid", m_valid, 1);
        chk("post_rst_w1", $signed(w1), 4);
        chk("post_rst_w2", $signed(w2), -4);
        // Load while an update is held.
        do_load(1, 1);

        // Random batches with random gaps and back-pressure.
        mr_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int rx1, rx2, re;
            rx1 = int'($urandom_range(0, 15)) - 8;
            rx2 = int'($urandom_range(0, 15)) - 8;
            re  = int'($urandom_range(0, 31)) - 16;
            send(rx1, rx2, re, int'($urandom_range(0, 3) != 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (BATCH - cntm) send(1, 1, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
